mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed data-memory responder that services load/store requests from the CPU datapath over a valid/ready request channel and a valid/ready response channel. It replaces the single-cycle data-memory path with a fixed-latency, one-outstanding-request slave. The CPU is the initiator and this block is the responder; the block owns the storage array and is the only writer of it.

## Interface
- `DATA_W`, 16, data word width in bits
- `ADDR_W`, 16, request address width in bits (word address)
- `DEPTH_LOG2`, 10, log2 of implemented words; addresses at or above 2**DEPTH_LOG2 are out of range
- `LATENCY`, 4, cycles from request accept to response/commit; legal range 1..15
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  initiator presents a request
- `req_ready`  out  1  responder can accept a request this cycle
- `req_wr`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  word address
- `req_wdata`  in  DATA_W  store data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  initiator accepts response
- `rsp_rdata`  out  DATA_W  load data; 0 for stores and errors
- `rsp_err`  out  1  request was out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready` latch wr/addr/wdata, compute out-of-range flag, load latency counter with LATENCY-1. Go to WAIT if LATENCY>1, else complete immediately (see commit).
- WAIT: `req_ready`=0; counter decrements each cycle; at counter 0, commit.
- Commit: load -> capture array[addr] (or 0 if out of range) into `rsp_rdata`; store -> write array[addr] if in range, else drop. Then go to RESP (or IDLE for stores without write ack, see Configuration).
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_err` held stable until `rsp_ready`. On `rsp_valid & rsp_ready` go to IDLE. `req_ready`=0 in RESP.
- Exactly one outstanding request; no pipelining; request channel blocked in WAIT and RESP.
- Address range check uses the full ADDR_W; array indexed by low DEPTH_LOG2 bits only when in range.
- `req_*` inputs ignored outside IDLE; latched values are used, not live inputs.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0. Array contents are not cleared by reset.
- Request accepted at edge N -> commit at edge N+LATENCY -> `rsp_valid` high from edge N+LATENCY.
- `rsp_ready` held high: return to IDLE one cycle after `rsp_valid` rises; next request accepted earliest at edge N+LATENCY+2. Throughput one request per LATENCY+2 cycles minimum (LATENCY+1 for unacknowledged stores).
- `rsp_ready` low: response held indefinitely, no timeout.
- `rst` asserted mid-WAIT: request aborted, store not committed. Mid-RESP: response dropped, store already committed remains.
- Load after store to same address: returns new data (commit precedes next accept).

## Configuration
- `MEM_RESP_WRITE_ACK_EN` defined: stores produce a response (`rsp_valid`, `rsp_rdata`=0, `rsp_err` per range check) and follow WAIT->RESP->IDLE.
- Not defined: stores go WAIT->IDLE at commit with no response; `rsp_valid` asserted for loads only; out-of-range stores dropped silently.

## Structure
- Package `mem_resp_pkg`: FSM state enum (IDLE, WAIT, RESP), default DATA_W/ADDR_W/DEPTH_LOG2/LATENCY constants, counter width constant (4 bits).
- Sub-module `mem_resp_array`: synchronous single-port storage (clk, we, addr, wdata, rdata), no reset; the FSM/counter/handshake stays in `mem_responder`.

## Test plan
- Reset, then store 0xBEEF to 0x0010 (LATENCY=4, write ack on) -> `req_ready` drops next cycle, `rsp_valid` at accept+4 with `rsp_err`=0, `rsp_rdata`=0; subsequent load 0x0010 -> `rsp_rdata`=0xBEEF at accept+4.
- Load 0x0400 (DEPTH_LOG2=10) -> `rsp_err`=1, `rsp_rdata`=0; store 0x1234 to 0x0400 then load 0x0000 -> 0x0000 unchanged (no aliasing).
- Hold `rsp_ready` low 10 cycles on a load of 0x0005 holding 0x00A5 -> `rsp_valid`, `rsp_rdata`=0x00A5 stable all 10 cycles; `req_valid` with new request ignored until handshake completes.
- Assert `rst` two cycles into WAIT of a store 0x5555 to 0x0020 (previously 0x1111) -> outputs return to reset values; load 0x0020 -> 0x1111.
- LATENCY=1, back-to-back loads with `rsp_ready`=1 -> responses one cycle after each accept; accepts spaced 3 cycles apart.
- `MEM_RESP_WRITE_ACK_EN` undefined: store 0x0F0F to 0x0003 -> `rsp_valid` never asserts, `req_ready` high again at accept+LATENCY; load 0x0003 -> 0x0F0F.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and default sizing for the fixed-latency data-memory responder.
package mem_resp_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DEPTH_LOG2_DEF = 10;
  localparam int unsigned LATENCY_DEF    = 4;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_resp_if.sv
// Request/response valid-ready channel between the CPU datapath and the memory responder.
interface mem_resp_if
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_resp_array.sv
// Synchronous single-port word storage, read-first, no reset on contents.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AW     = DEPTH_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency, single-outstanding load/store responder owning the data array.
// Optional store acknowledge responses: define MEM_RESP_WRITE_ACK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF
) (
  input logic       clk,
  input logic       rst,
  mem_resp_if.slave bus
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  oor_q, oor_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  mem_we_c;
  logic [DEPTH_LOG2-1:0] mem_addr_c;
  logic [DATA_W-1:0]     mem_rdata;

  // Read the live address while idle so a LATENCY=1 load has its data by commit.
  assign mem_addr_c = (state_q == IDLE) ? bus.req_addr[DEPTH_LOG2-1:0] : idx_q;

  mem_resp_array #(
    .DATA_W (DATA_W),
    .AW     (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we_c),
    .addr_i  (mem_addr_c),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      oor_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      oor_q       <= oor_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    oor_d       = oor_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wr_d    = bus.req_wr;
          idx_d   = bus.req_addr[DEPTH_LOG2-1:0];
          wdata_d = bus.req_wdata;
          oor_d   = (bus.req_addr >> DEPTH_LOG2) != '0;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          mem_we_c = wr_q && !oor_q;
          if (!wr_q) begin
            rsp_rdata_d = oor_q ? '0 : mem_rdata;
            rsp_err_d   = oor_q;
            state_d     = RESP;
          end else begin
`ifdef MEM_RESP_WRITE_ACK_EN
            rsp_rdata_d = '0;
            rsp_err_d   = oor_q;
            state_d     = RESP;
`else
            state_d     = IDLE;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 4 and 1) against a transaction-level model.
module tb_mem_responder;

`ifdef MEM_RESP_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_wr    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_resp_if #(.DATA_W(16), .ADDR_W(16)) bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_wr    = req_wr[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;
    mem_responder #(
      .DATA_W (16), .ADDR_W (16), .DEPTH_LOG2 (10), .LATENCY ((g == 0) ? 4 : 1)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Model state: one transaction in flight per instance, plus expected memory contents.
  int          edge_n;
  bit          pend    [2];
  bit          p_wr    [2];
  bit          p_resp  [2];
  bit          p_err   [2];
  bit          p_known [2];
  int          p_acc   [2];
  logic [9:0]  p_idx   [2];
  logic [15:0] p_wdata [2];
  logic [15:0] p_data  [2];
  logic [15:0] mm [2][0:1023];
  bit          mk [2][0:1023];
  int          n_pass, n_total;

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_edge();
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
      end else if (!pend[k]) begin
        if (req_valid[k]) begin
          pend[k]    = 1'b1;
          p_acc[k]   = edge_n;
          p_wr[k]    = req_wr[k];
          p_idx[k]   = req_addr[k][9:0];
          p_wdata[k] = req_wdata[k];
          p_err[k]   = req_addr[k] >= 16'd1024;
          p_resp[k]  = !req_wr[k] || ACK;
          if (req_wr[k]) begin
            p_data[k]  = 16'h0;
            p_known[k] = 1'b1;
          end else begin
            p_data[k]  = p_err[k] ? 16'h0 : mm[k][req_addr[k][9:0]];
            p_known[k] = p_err[k] || mk[k][req_addr[k][9:0]];
          end
        end
      end else if (edge_n == p_acc[k] + lat(k)) begin
        if (p_wr[k] && !p_err[k]) begin
          mm[k][p_idx[k]] = p_wdata[k];
          mk[k][p_idx[k]] = 1'b1;
        end
        if (!p_resp[k]) pend[k] = 1'b0;
      end else if (edge_n > p_acc[k] + lat(k) && rsp_ready[k]) begin
        pend[k] = 1'b0;
      end
    end
  endtask

  task automatic model_cmp();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        chk($sformatf("rst_state%0d", k),
            {15'd0, req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]}, {15'd0, 1'b1, 1'b0, 1'b0, 16'h0});
      end else if (!pend[k]) begin
        chk($sformatf("idle%0d", k), {30'd0, req_ready[k], rsp_valid[k]}, {30'd0, 1'b1, 1'b0});
      end else if (edge_n < p_acc[k] + lat(k)) begin
        chk($sformatf("wait%0d", k), {30'd0, req_ready[k], rsp_valid[k]}, {30'd0, 1'b0, 1'b0});
      end else begin
        chk($sformatf("resp%0d", k), {29'd0, req_ready[k], rsp_valid[k], rsp_err[k]},
            {29'd0, 1'b0, 1'b1, p_err[k]});
        if (p_known[k]) chk($sformatf("rdata%0d", k), 32'(rsp_rdata[k]), 32'(p_data[k]));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int k, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      output int acc);
    bit r;
    bit got;
    got = 1'b0;
    acc = -1;
    req_valid[k] = 1'b1; req_wr[k] = wr; req_addr[k] = a; req_wdata[k] = d;
    for (int n = 0; n < 40; n++) begin
      r = req_ready[k];
      tick(1);
      if (r) begin
        got = 1'b1;
        acc = edge_n;
        break;
      end
    end
    req_valid[k] = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (pend[k] && n < 60) begin
      tick(1);
      n++;
    end
    if (pend[k]) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic stim();
    int a0, a1, a2;
    tick(3);
    rst = 1'b0;
    chk("reset_lit", {15'd0, req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]},
        {15'd0, 1'b1, 1'b0, 1'b0, 16'h0});

    // Store then load the same word.
    send(0, 1'b1, 16'h0010, 16'hBEEF, a0);
    chk("st_ready_drop", 32'(req_ready[0]), 32'd0);
    tick(3);
    chk("st_valid_early", 32'(rsp_valid[0]), 32'd0);
    tick(1);
    chk("st_ack", {29'd0, rsp_valid[0], rsp_err[0], req_ready[0]}, {29'd0, ACK, 1'b0, !ACK});
    wait_done(0);
    send(0, 1'b0, 16'h0010, 16'h0, a0);
    tick(4);
    chk("ld_beef", {15'd0, rsp_valid[0], rsp_rdata[0]}, {15'd0, 1'b1, 16'hBEEF});
    wait_done(0);

    // Out-of-range load and store, no aliasing onto word 0.
    send(0, 1'b0, 16'h0400, 16'h0, a0);
    tick(4);
    chk("ld_oor", {15'd0, rsp_err[0], rsp_rdata[0]}, {15'd0, 1'b1, 16'h0});
    wait_done(0);
    send(0, 1'b1, 16'h0000, 16'h0000, a0); wait_done(0);
    send(0, 1'b1, 16'h0400, 16'h1234, a0); wait_done(0);
    send(0, 1'b0, 16'h0000, 16'h0, a0);
    tick(4);
    chk("no_alias", {15'd0, rsp_err[0], rsp_rdata[0]}, {15'd0, 1'b0, 16'h0000});
    wait_done(0);

    // Back-pressure: response held while a new request waits.
    send(0, 1'b1, 16'h0005, 16'h00A5, a0); wait_done(0);
    rsp_ready[0] = 1'b0;
    send(0, 1'b0, 16'h0005, 16'h0, a0);
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 16'h0010;
    tick(4);
    for (int i = 0; i < 10; i++) begin
      chk("hold", {14'd0, rsp_valid[0], req_ready[0], rsp_rdata[0]}, {14'd0, 1'b1, 1'b0, 16'h00A5});
      tick(1);
    end
    rsp_ready[0] = 1'b1;
    send(0, 1'b0, 16'h0010, 16'h0, a1);
    chk("held_accept_edge", 32'(a1 - a0), 32'd16);
    tick(4);
    chk("after_hold", 32'(rsp_rdata[0]), 32'h0000BEEF);
    wait_done(0);

    // Reset two cycles into the WAIT of a store aborts it.
    send(0, 1'b1, 16'h0020, 16'h1111, a0); wait_done(0);
    send(0, 1'b1, 16'h0020, 16'h5555, a0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("mid_rst", {15'd0, req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]},
        {15'd0, 1'b1, 1'b0, 1'b0, 16'h0});
    rst = 1'b0;
    tick(1);
    send(0, 1'b0, 16'h0020, 16'h0, a0);
    tick(4);
    chk("rst_abort", 32'(rsp_rdata[0]), 32'h00001111);
    wait_done(0);

    // LATENCY=1 instance: back-to-back loads.
    send(1, 1'b1, 16'h0001, 16'h0101, a0); wait_done(1);
    send(1, 1'b1, 16'h0002, 16'h0202, a0); wait_done(1);
    send(1, 1'b0, 16'h0001, 16'h0, a0);
    send(1, 1'b0, 16'h0002, 16'h0, a1);
    chk("l1_gap_a", 32'(a1 - a0), 32'd3);
    tick(1);
    chk("l1_rsp", {15'd0, rsp_valid[1], rsp_rdata[1]}, {15'd0, 1'b1, 16'h0202});
    send(1, 1'b0, 16'h0001, 16'h0, a2);
    chk("l1_gap_b", 32'(a2 - a1), 32'd3);
    wait_done(1);

    // Store response behaviour depends on the write-ack build option.
    send(0, 1'b1, 16'h0003, 16'h0F0F, a0);
    tick(4);
    chk("st_done", {30'd0, req_ready[0], rsp_valid[0]}, {30'd0, !ACK, ACK});
    wait_done(0);
    send(0, 1'b0, 16'h0003, 16'h0, a0);
    tick(4);
    chk("ld_0f0f", 32'(rsp_rdata[0]), 32'h00000F0F);
    wait_done(0);
    tick(3);
  endtask

  initial begin
    rst = 1'b1;
    edge_n = 0;
    n_pass = 0;
    n_total = 0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_wr[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      rsp_ready[k] = 1'b1; pend[k] = 1'b0;
      for (int i = 0; i < 1024; i++) mk[k][i] = 1'b0;
    end
    fork
      forever begin
        @(posedge clk or negedge clk);
        if (clk) model_edge();
        else model_cmp();
      end
      stim();
    join_any
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
